button_debouncer: RTL

Front-end conditioning stage for the board push-buttons, placed directly upstream of the AHB button peripheral. It synchronises up to 8 raw, bouncing, asynchronous button pins into the HCLK domain and filters each one with a per-channel counter FSM. It then drives a clean debounced level bus, which the AHB peripheral samples as its BUTTON input, plus single-cycle press/release event pulses for interrupt logic.

---
 rtl/btn_pkg.sv | 16 +
 rtl/button_debounce_chan.sv | 102 ++++++++++
 rtl/button_debouncer.sv | 43 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: default sizing and
// the per-channel filter state encoding.
package btn_pkg;

  localparam int unsigned DEFAULT_WIDTH           = 8;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_CNT_W           = 20;

  // STABLE: sampled value agrees with the accepted level.
  // PENDING: a candidate change is being timed.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/button_debounce_chan.sv
// Single debounce channel: 2-flop synchroniser, optional inversion, and a
// counter FSM that accepts a change only after DEBOUNCE_CYCLES+1
// consecutive samples of the new value.
// Ports:
//   HCLK     system clock, rising edge
//   HRESET   asynchronous active-high reset
//   raw      raw asynchronous button pin
//   inv      1 = pin is active-low (tied constant)
//   level    debounced level, 1 = pressed
//   press    one-cycle pulse on level 0->1
//   rel      one-cycle pulse on level 1->0
module button_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic raw,
  input  logic inv,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             press_nxt;
  logic             rel_nxt;

  // Synchroniser; reset to the inactive pin level so s resets to 0.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1 <= inv;
      sync2 <= inv;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ inv;

  // Filter state, counter and registered outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    level_nxt = level;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    unique case (state)
      ST_STABLE: begin
        if (s != level) begin
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (s == level) begin
          state_nxt = ST_STABLE;
        end else if (cnt == CNT_LAST) begin
          // Commit: the pulse coincides with the level edge.
          state_nxt = ST_STABLE;
          level_nxt = ~level;
          press_nxt = ~level;
          rel_nxt   = level;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_STABLE;
      end
    endcase
  end

endmodule

// File: rtl/button_debouncer.sv
// Front-end conditioning for the board push-buttons: one independent
// debounce channel per pin, producing a clean level bus plus press/release
// event pulses.
// Ports:
//   HCLK     system clock, rising edge
//   HRESET   asynchronous active-high reset
//   BTN_RAW  raw asynchronous button pins
//   BUTTON   debounced level, 1 = pressed
//   PRESS    one-cycle pulse when BUTTON bit goes 0->1
//   RELEASE  one-cycle pulse when BUTTON bit goes 1->0
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned     WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned     DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned     CNT_W           = DEFAULT_CNT_W,
  parameter logic [WIDTH-1:0] INVERT         = '0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] BTN_RAW,
  output logic [WIDTH-1:0] BUTTON,
  output logic [WIDTH-1:0] PRESS,
  output logic [WIDTH-1:0] RELEASE
);

  // One filter per pin; channels share nothing but clock and reset.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .raw    (BTN_RAW[i]),
      .inv    (INVERT[i]),
      .level  (BUTTON[i]),
      .press  (PRESS[i]),
      .rel    (RELEASE[i])
    );
  end

endmodule
